rr_arb_mux: RTL and testbench



---
 rtl/rr_arb_mux.sv | 122 ++++++++++++
 tb/tb_rr_arb_mux.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - round-robin N:1 stream arbiter with registered output stage
// Optional burst lock on in_last: RR_ARB_MUX_LOCK_EN
module rr_arb_mux #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
`endif
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_sel_q, out_sel_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
`ifdef RR_ARB_MUX_LOCK_EN
    logic                lock_q, lock_d;
    logic [SEL_W-1:0]    lock_ch_q, lock_ch_d;
`endif

    logic                load;
    logic                accept;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [SEL_W-1:0]    idx;
    int                  idx_i;

    // Search from the highest offset down so the channel nearest ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = '0;
        idx_i     = 0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx_i = int'(ptr_q) + k;
            if (idx_i >= CHANNELS) idx_i = idx_i - CHANNELS;
            idx = SEL_W'(idx_i);
            if (in_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
`ifdef RR_ARB_MUX_LOCK_EN
        if (lock_q) begin
            grant            = '0;
            grant[lock_ch_q] = in_valid[lock_ch_q];
            grant_idx        = lock_ch_q;
        end
`endif
    end

    assign load     = !out_valid_q || out_ready;
    assign accept   = load && (|grant);
    // Gated by rst_n so no producer sees ready while the stage is held in reset.
    assign in_ready = rst_n ? (grant & {CHANNELS{load}}) : '0;

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
`ifdef RR_ARB_MUX_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (accept) begin
            out_data_d  = in_data[grant_idx*WIDTH +: WIDTH];
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            ptr_d       = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
            if (in_last[grant_idx]) begin
                lock_d = 1'b0;
            end else begin
                lock_d    = 1'b1;
                lock_ch_d = grant_idx;
                ptr_d     = ptr_q;
            end
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - directed-vector bench for rr_arb_mux (WIDTH=8, CHANNELS=4)
module tb_rr_arb_mux;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    logic                      clk;
    logic                      rst_n;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
`ifdef RR_ARB_MUX_LOCK_EN
    logic [CHANNELS-1:0]       in_last;
`endif
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_valid;
    logic                      out_ready;

    int n_vec;
    int n_err;

    rr_arb_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_last   (in_last),
`endif
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input int sel, input int data);
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " sel"}, 32'(out_sel), 32'(sel));
        check({tag, " data"}, 32'(out_data), 32'(data));
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_data   = '0;
        out_ready = 1'b1;
`ifdef RR_ARB_MUX_LOCK_EN
        in_last   = 4'h0;
`endif

        // 1: reset state
        tick();
        tick();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'h00);
        check("rst out_sel", 32'(out_sel), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'h0);

        // 2: single channel
        rst_n    = 1'b1;
        in_valid = 4'b0100;
        in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
        #1;
        check("single in_ready", 32'(in_ready), 32'b0100);
        tick();
        expect_beat("single", 2, 8'hA5);
        in_valid = 4'b0000;
        tick();
        check("single drain", 32'(out_valid), 32'd0);

        // 1b: async reset drops a held beat mid-cycle
        in_valid  = 4'b0001;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        tick();
        out_ready = 1'b0;
        in_valid  = 4'b0000;
        check("pre-arst valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst valid", 32'(out_valid), 32'd0);
        check("arst data", 32'(out_data), 32'h00);
        tick();

        // 3: round-robin with all channels valid
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        #1;
        check("rr first in_ready", 32'(in_ready), 32'b0001);
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_beat($sformatf("rr%0d", i), i % 4, 8'h10 + (i % 4));
        end

        // 4: backpressure holds beat 0x11 from ch1
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("stall%0d in_ready", i), 32'(in_ready), 32'h0);
            tick();
            expect_beat($sformatf("stall%0d", i), 1, 8'h11);
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(in_ready), 32'b0100);
        tick();
        expect_beat("release0", 2, 8'h12);
        tick();
        expect_beat("release1", 3, 8'h13);

        // 5: wrap-around after ch3 with only ch0/ch1 valid
        in_valid = 4'b0011;
        tick();
        expect_beat("wrap0", 0, 8'h10);
        tick();
        expect_beat("wrap1", 1, 8'h11);
        tick();
        expect_beat("wrap2", 0, 8'h10);

`ifdef RR_ARB_MUX_LOCK_EN
        // 6: ch1 burst of three locks out ch0 (ptr is 1 here)
        in_valid = 4'b0011;
        in_last  = 4'b0000;
        tick();
        expect_beat("lock0", 1, 8'h11);
        tick();
        expect_beat("lock1", 1, 8'h11);
        in_valid = 4'b0001;
        #1;
        check("lock hole in_ready", 32'(in_ready), 32'h0);
        tick();
        check("lock hole drain", 32'(out_valid), 32'd0);
        in_valid = 4'b0011;
        in_last  = 4'b0010;
        tick();
        expect_beat("lock2", 1, 8'h11);
        in_last = 4'b0000;
        tick();
        expect_beat("unlock", 0, 8'h10);
`endif

        in_valid = 4'b0000;
        tick();
        check("final drain", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
